register_write_arbiter: RTL and testbench

Round-robin arbiter that shares one N-bit parallel load register between R write requesters. It sits directly in front of the register: it collects per-requester write requests, grants exactly one at a time, and drives the register's `load` and `d` inputs. Optional bounded burst locking lets a requester perform back-to-back writes without re-arbitrating.

---
 rtl/register_ctrl_pkg.sv | 14 +
 rtl/rr_picker.sv | 31 +++
 rtl/register_write_arbiter.sv | 122 ++++++++++++
 tb/tb_register_write_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/register_ctrl_pkg.sv
// Shared definitions for register write-control blocks: FSM state encoding
// and the index width helper used to size requester indices.
package register_ctrl_pkg;

    // Arbiter FSM state encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned index_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first asserted request,
// searching upward from ptr+1 and wrapping modulo R.
module rr_picker
    import register_ctrl_pkg::*;
#(
    parameter int unsigned R  = 4,
    parameter int unsigned IW = index_w(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = R; k >= 1; k--) begin
            pos = IW'((32'(ptr) + k) % R);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter in front of a shared N-bit load register.
// One idle arbitration cycle precedes each grant; a granted requester may
// hold the grant for up to MAX_BURST back-to-back writes by asserting lock.
module register_write_arbiter
    import register_ctrl_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned R         = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R-1:0]   lock,
    input  logic [R*N-1:0] data,
    output logic [R-1:0]   ack,
    output logic [R-1:0]   grant,
    output logic           load,
    output logic [N-1:0]   d,
    output logic           busy
);

    localparam int unsigned IW = index_w(R);
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;
    // bcnt+1 < MAX_BURST rewritten as bcnt < MAX_BURST-1 to avoid overflow.
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [IW-1:0] PTR_RST    = IW'(R - 1);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          owner_lock;
    logic          stay;
    logic [R-1:0]  sel_onehot;
    logic [N-1:0]  slots [R];

    // Unflatten the write data bus into per-requester slots.
    for (genvar i = 0; i < R; i++) begin : g_slots
        assign slots[i] = data[i*N +: N];
    end

    // Picker sees only registered ptr; selection is registered into sel.
    rr_picker #(
        .R  (R),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req  = req[sel_q];
    assign owner_lock = lock[sel_q];
    assign sel_onehot = {{(R-1){1'b0}}, 1'b1} << sel_q;
    assign stay       = owner_req & owner_lock & (bcnt_q < BURST_LAST);

    // Next-state logic: arbitrate in IDLE, count writes and release in GRANT.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    bcnt_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (load) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
                if (!stay) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel_q;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= PTR_RST;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Register-side outputs; a write is suppressed while rst is asserted.
    always_comb begin
        busy  = (state_q == ST_GRANT);
        grant = '0;
        ack   = '0;
        load  = 1'b0;
        d     = '0;
        if (busy) begin
            grant = sel_onehot;
            load  = owner_req & ~rst;
            if (load) begin
                ack = sel_onehot;
                d   = slots[sel_q];
            end
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed, table-driven bench for register_write_arbiter (N=8, R=4, MAX_BURST=4).
module tb_register_write_arbiter;

    localparam int unsigned N = 8;
    localparam int unsigned R = 4;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] data;
        logic        load;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic [7:0]  d;
        logic        busy;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [R-1:0]   req;
    logic [R-1:0]   lock;
    logic [R*N-1:0] data;
    logic [R-1:0]   ack;
    logic [R-1:0]   grant;
    logic           load;
    logic [N-1:0]   d;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    register_write_arbiter #(
        .N         (N),
        .R         (R),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .data  (data),
        .ack   (ack),
        .grant (grant),
        .load  (load),
        .d     (d),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [31:0] dt, input logic ld, input logic [3:0] ak,
                                input logic [3:0] gt, input logic [7:0] dd, input logic bz);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.data = dt;
        v.load = ld; v.ack = ak; v.grant = gt; v.d = dd; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] DRR = 32'h44332211;
    localparam logic [31:0] DA5 = 32'h000000A5;

    initial begin
        int cyc;
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        data = DRR;

        // Idle-reset state, then a single request from requester 0.
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DA5, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, DA5, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, DA5, 1, 4'b0001, 4'b0001, 8'hA5, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DA5, 0, 4'b0000, 4'b0000, 8'h00, 0));
        // Reset so ptr=R-1, then all four requesting: order 0,1,2,3,0.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b0010, 4'b0010, 8'h22, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b1000, 4'b1000, 8'h44, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        // Locked burst by 2 (ptr=0) with 0 also waiting: four writes, then 0.
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        // Burst by 1, req[1] dropped after two writes; then 2 preferred over 3.
        vecs.push_back(mk(0, 4'b0010, 4'b0010, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, DRR, 1, 4'b0010, 4'b0010, 8'h22, 1));
        vecs.push_back(mk(0, 4'b1110, 4'b0010, DRR, 1, 4'b0010, 4'b0010, 8'h22, 1));
        vecs.push_back(mk(0, 4'b1100, 4'b0010, DRR, 0, 4'b0000, 4'b0010, 8'h00, 1));
        vecs.push_back(mk(0, 4'b1100, 4'b0010, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1100, 4'b0010, DRR, 1, 4'b0100, 4'b0100, 8'h33, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        // Reset during the third write of a locked burst by 0.
        vecs.push_back(mk(0, 4'b0001, 4'b0001, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(1, 4'b0001, 4'b0001, DRR, 0, 4'b0000, 4'b0001, 8'h00, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, DRR, 1, 4'b0001, 4'b0001, 8'h11, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, DRR, 0, 4'b0000, 4'b0000, 8'h00, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            lock = vecs[i].lock;
            data = vecs[i].data;
            #1;
            chk("load",  i, 32'(load),  32'(vecs[i].load));
            chk("ack",   i, 32'(ack),   32'(vecs[i].ack));
            chk("grant", i, 32'(grant), 32'(vecs[i].grant));
            chk("d",     i, 32'(d),     32'(vecs[i].d));
            chk("busy",  i, 32'(busy),  32'(vecs[i].busy));
            @(negedge clk);
        end

        // Latency: request from 1 (ptr=0) must load on the second cycle.
        rst  = 1'b0;
        req  = 4'b0010;
        lock = 4'b0000;
        data = DRR;
        cyc  = 0;
        #1;
        while (!load && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("lat_cycles", 100, 32'(cyc), 32'd1);
        chk("lat_ack",    100, 32'(ack), 32'h2);
        chk("lat_d",      100, 32'(d),   32'h22);
        req = 4'b0000;
        @(negedge clk);
        #1;
        chk("lat_release", 101, 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
